// File: rtl/clockworks_pkg.sv
// Shared defaults and helpers for the clockworks clock/reset front-end.
package clockworks_pkg;

  localparam int CLOCKWORKS_SLOW_DEFAULT = 24;
  localparam int RST_SYNC_STAGES_DEFAULT = 2;
  localparam int RST_HOLD_DEFAULT        = 4;

  // Hold counter must be able to represent RST_HOLD itself.
  function automatic int hold_width(input int rst_hold);
    return (rst_hold < 1) ? 1 : $clog2(rst_hold + 1);
  endfunction

endpackage

// File: rtl/clockworks_reset_sync.sv
// Async-assert / sync-release reset synchronizer with parameterized depth (STAGES >= 2).
module clockworks_reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rel
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[STAGES-2:0], 1'b1};
  end

  assign rel = sync[STAGES-1];

endmodule

// File: rtl/clockworks.sv
// Board clock divider and system reset generator; resetn only releases on a clk falling edge.
// Optional clk_en output (pulse before each clk rise) is built when CLOCKWORKS_CLKEN_EN is defined.
module clockworks
  import clockworks_pkg::*;
#(
  parameter int SLOW            = CLOCKWORKS_SLOW_DEFAULT,
  parameter int RST_SYNC_STAGES = RST_SYNC_STAGES_DEFAULT,
  parameter int RST_HOLD        = RST_HOLD_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic resetn
`ifdef CLOCKWORKS_CLKEN_EN
  ,
  output logic clk_en
`endif
);

  localparam int HW = hold_width(RST_HOLD);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(RST_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  logic          rel;
  logic [HW-1:0] hold;

  clockworks_reset_sync #(
    .STAGES(RST_SYNC_STAGES)
  ) u_reset_sync (
    .clk(CLK),
    .rst(RESET),
    .rel(rel)
  );

  generate
    if (SLOW == 0) begin : g_bypass
      assign clk = CLK;

      // clk is CLK here, so its falling edge is the CLK falling edge.
      always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
          hold   <= '0;
          resetn <= 1'b0;
        end else if (rel && (hold < HOLD_MAX)) begin
          hold <= hold + 1'b1;
          if (hold == HOLD_LAST) resetn <= 1'b1;
        end
      end

`ifdef CLOCKWORKS_CLKEN_EN
      assign clk_en = resetn;
`endif
    end else begin : g_div
      logic [SLOW:0] div;
      logic          fall;

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) div <= '0;
        else       div <= div + 1'b1;
      end

      assign clk  = div[SLOW];
      // All-ones means this CLK edge wraps div, taking div[SLOW] from 1 to 0.
      assign fall = &div;

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          hold   <= '0;
          resetn <= 1'b0;
        end else if (fall && rel && (hold < HOLD_MAX)) begin
          hold <= hold + 1'b1;
          if (hold == HOLD_LAST) resetn <= 1'b1;
        end
      end

`ifdef CLOCKWORKS_CLKEN_EN
      localparam logic [SLOW:0] EN_POINT = {1'b0, {SLOW{1'b1}}};
      assign clk_en = resetn && (div == EN_POINT);
`endif
    end
  endgenerate

endmodule

// File: tb/tb_clockworks.sv
// Randomized self-checking bench for clockworks at SLOW = 2, 1, 0 and 24.
module tb_clockworks;

  logic CLK = 1'b0;
  logic RESET;
  logic clk2, clk1, clk0, clk24;
  logic rstn2, rstn1, rstn0, rstn24;
`ifdef CLOCKWORKS_CLKEN_EN
  logic en2, en1, en0, en24;
`endif

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 CLK = ~CLK;

  clockworks #(.SLOW(2), .RST_SYNC_STAGES(2), .RST_HOLD(4)) u_s2 (
    .CLK(CLK), .RESET(RESET), .clk(clk2), .resetn(rstn2)
`ifdef CLOCKWORKS_CLKEN_EN
    , .clk_en(en2)
`endif
  );

  clockworks #(.SLOW(1), .RST_SYNC_STAGES(3), .RST_HOLD(2)) u_s1 (
    .CLK(CLK), .RESET(RESET), .clk(clk1), .resetn(rstn1)
`ifdef CLOCKWORKS_CLKEN_EN
    , .clk_en(en1)
`endif
  );

  clockworks #(.SLOW(0), .RST_SYNC_STAGES(2), .RST_HOLD(4)) u_s0 (
    .CLK(CLK), .RESET(RESET), .clk(clk0), .resetn(rstn0)
`ifdef CLOCKWORKS_CLKEN_EN
    , .clk_en(en0)
`endif
  );

  clockworks u_s24 (
    .CLK(CLK), .RESET(RESET), .clk(clk24), .resetn(rstn24)
`ifdef CLOCKWORKS_CLKEN_EN
    , .clk_en(en24)
`endif
  );

  // n = CLK rising edges seen with RESET low since the last release.
  function automatic logic m_clk(input int slow, input int edges);
    return logic'((edges >> slow) & 1);
  endfunction

  function automatic logic m_rstn(input int slow, input int stages, input int hold,
                                  input int edges, input bit after_neg);
    int cnt = 0;
    if (slow == 0) begin
      cnt = after_neg ? edges - stages + 1 : edges - stages;
    end else begin
      for (int k = 1; k <= edges; k++)
        if ((k % (1 << (slow + 1))) == 0 && k > stages) cnt++;
    end
    return cnt >= hold;
  endfunction

  function automatic logic m_en(input int slow, input int stages, input int hold,
                                input int edges, input bit after_neg);
    if (slow == 0) return m_rstn(0, stages, hold, edges, after_neg);
    return ((edges % (1 << (slow + 1))) == ((1 << slow) - 1)) &&
           m_rstn(slow, stages, hold, edges, after_neg);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (t=%0t n=%0d)", tag, obs, exp, $time, n);
    end
  endtask

  task automatic check_all(input bit after_neg);
    chk("clk_s2",    clk2,   m_clk(2, n));
    chk("resetn_s2", rstn2,  m_rstn(2, 2, 4, n, after_neg));
    chk("clk_s1",    clk1,   m_clk(1, n));
    chk("resetn_s1", rstn1,  m_rstn(1, 3, 2, n, after_neg));
    chk("clk_s0",    clk0,   after_neg ? 1'b0 : 1'b1);
    chk("resetn_s0", rstn0,  m_rstn(0, 2, 4, n, after_neg));
    chk("clk_s24",   clk24,  m_clk(24, n));
    chk("resetn_s24", rstn24, m_rstn(24, 2, 4, n, after_neg));
`ifdef CLOCKWORKS_CLKEN_EN
    chk("clk_en_s2",  en2,  m_en(2, 2, 4, n, after_neg));
    chk("clk_en_s1",  en1,  m_en(1, 3, 2, n, after_neg));
    chk("clk_en_s0",  en0,  m_en(0, 2, 4, n, after_neg));
    chk("clk_en_s24", en24, m_en(24, 2, 4, n, after_neg));
`endif
  endtask

  // Called in the CLK low phase right after RESET rises, before any edge.
  task automatic check_async();
    chk("async_clk_s2",     clk2,   1'b0);
    chk("async_resetn_s2",  rstn2,  1'b0);
    chk("async_clk_s1",     clk1,   1'b0);
    chk("async_resetn_s1",  rstn1,  1'b0);
    chk("async_resetn_s0",  rstn0,  1'b0);
    chk("async_clk_s24",    clk24,  1'b0);
    chk("async_resetn_s24", rstn24, 1'b0);
`ifdef CLOCKWORKS_CLKEN_EN
    chk("async_clk_en_s2", en2, 1'b0);
    chk("async_clk_en_s0", en0, 1'b0);
`endif
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      if (!RESET) n++;
      #1 check_all(1'b0);
      @(negedge CLK);
      #1 check_all(1'b1);
    end
  endtask

  initial begin
    RESET = 1'b1;
    n = 0;
    #1 check_all(1'b1);
    step(3);
    #2 RESET = 1'b0;

    for (int round = 0; round < 4; round++) begin
      step(int'($urandom_range(70, 40)));
      // Async reset mid-run, in the CLK low phase so no edge is involved.
      #1 RESET = 1'b1;
      n = 0;
      #1 check_async();
      if ($urandom_range(1, 0) == 1) begin
        #1 RESET = 1'b0;
      end else begin
        step(int'($urandom_range(3, 1)));
        #2 RESET = 1'b0;
      end
    end

    // Long run: SLOW=24 must still show clk=0 and resetn=0.
    step(110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
